control_fsm: RTL and testbench
==============================

# control_fsm

Multicycle control unit for the 8-bit DE10-Lite processor. It fetches instructions from the shared memory, holds the PC and IR, and sequences the existing datapath through decode and execute. The datapath is the register file, the ALU and the memory. The block replaces the switch/KEY-driven register-file write path and drives every datapath control strobe: MemRead, MemWrite, ADDR, Data_in, ALUop, RFWrite, register selects and write-back select.

## Interface
Parameters:
- `PC_RESET`, 8'h00, PC value loaded on reset.

Ports:
- `CLOCK_50`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `step`  in  1  single-cycle pulse that advances one instruction; used only with CTRL_SINGLE_STEP_EN.
- `Data_out`  in  8  memory read data, valid the cycle after MemRead.
- `dataA`, `dataB`  in  8 each  register-file read ports A and B.
- `N`, `Z`  in  1 each  combinational ALU flags.
- `MemRead`, `MemWrite`  out  1 each  memory strobes.
- `ADDR`  out  8  memory address.
- `Data_in`  out  8  store data, always equal to `dataA`.
- `ALUop`  out  3  ALU operation: 000 add, 001 sub, 010 nand.
- `RFWrite`  out  1  register-file write enable.
- `regA`, `regB`, `regW`  out  2 each  register selects; the top level zero-extends them to 4 bits.
- `WBsel`  out  1  write-back source: 0 selects ALUout, 1 selects Data_out.
- `PC`, `IR`  out  8 each  architectural state, routed to the HEX displays.
- `halted`  out  1  high after STOP.

## Operation
- Instruction format: IR[7:6]=rx, IR[5:4]=ry, IR[3:0]=opcode. Branches use IR[7:4] as signed imm4.
- Opcodes:
  - 0 LOAD: rx ← M[ry].
  - 1 STORE: M[ry] ← rx.
  - 2 ADD, 3 SUB, 4 NAND: rx ← rx op ry.
  - 5 BZ, 6 BNZ, 7 BPL: conditional branch.
  - 8 STOP.
  - 9–F: NOP.
- Register selects decode continuously from IR: `regA`=IR[7:6], `regB`=IR[5:4], `regW`=IR[7:6].
- Outputs are Moore, decoded from the registered state. Every strobe is 0 unless its state is listed below.
- States:
  - RST: all strobes 0, `ADDR`=0 → FETCH (or STEPWAIT with the macro).
  - FETCH: `MemRead`=1, `ADDR`=PC → FWAIT.
  - FWAIT: IR ← Data_out, PC ← PC+1 → DECODE.
  - DECODE: `ALUop` is driven from the opcode. Next state by opcode:
    - 0 → LDRD.
    - 1 → ST.
    - 2/3/4 → ALUWB.
    - 5/6/7 → BR.
    - 8 → HALT.
    - otherwise → FETCH.
  - LDRD: `MemRead`=1, `ADDR`=dataB → LDWB.
  - LDWB: `RFWrite`=1, `WBsel`=1 → FETCH.
  - ST: `MemWrite`=1, `ADDR`=dataB → FETCH.
  - ALUWB: `RFWrite`=1, `WBsel`=0, `ALUop` held. Latch flags: Nf ← N, Zf ← Z → FETCH.
  - BR: if taken, PC ← PC + sext(imm4) → FETCH.
    - BZ is taken when Zf=1.
    - BNZ is taken when Zf=0.
    - BPL is taken when Nf=0.
  - HALT: `halted`=1, no strobes. Exits only through reset.
- Flags change only in ALUWB. LOAD and STORE do not affect them.
- PC arithmetic is modulo 256 and wraps in both directions. A branch offset applies to the already-incremented PC.

## Timing
- Reset values: state RST, PC=PC_RESET, IR=0, Nf=Zf=0, `halted`=0. All strobes 0, `ADDR`=0.
- Instruction latency from FETCH entry to the next FETCH entry:
  - ALU ops: 4 cycles.
  - STORE: 4 cycles.
  - Branches: 4 cycles.
  - NOP: 3 cycles.
  - LOAD: 5 cycles.
- `RFWrite` and `MemWrite` are each high for exactly one cycle per instruction.
- `ADDR`/`regB` are stable for the whole LDRD and ST cycle.
- Reset mid-instruction: the state is RST on the cycle after the reset edge. Any strobe in flight drops then, with no partial write-back.
- A reset held for multiple cycles keeps the block in RST.

## Configuration
- `CTRL_SINGLE_STEP_EN` defined:
  - Adds the STEPWAIT state, entered from RST and in place of every transition to FETCH.
  - STEPWAIT leaves for FETCH on the cycle after `step`=1.
  - All strobes are 0 in STEPWAIT.
- `CTRL_SINGLE_STEP_EN` undefined: `step` is ignored and the FSM free-runs.

## Test plan
- ADD: M[0]=8'h12, r0=3, r1=4 → in the 4th cycle after reset release, `RFWrite`=1, `regW`=0, `ALUop`=000, `WBsel`=0; PC=1; next cycle is FETCH with `ADDR`=1.
- LOAD: M[0]=8'hB0, dataB=8'h40 → LDRD has `MemRead`=1 with `ADDR`=8'h40; LDWB has `RFWrite`=1, `WBsel`=1, `regW`=2; 5-cycle instruction.
- STORE: M[0]=8'h41, dataA=8'h0A, dataB=8'h20 → single `MemWrite` cycle with `ADDR`=8'h20 and `Data_in`=8'h0A; `RFWrite` never asserts.
- Branch taken:
  - Setup: Zf=1 after a SUB with Z=1, then BZ 8'hE5 at PC=5.
  - Expected: PC=4.
  - Repeat with Zf=0: PC=6.
  - Wrap: BZ 8'hE5 at PC=8'hFF with Zf=1 → PC=8'hFE.
- STOP 8'h08 → `halted`=1 and no `MemRead` for 20 cycles. Reset asserted in the ST cycle → `MemWrite`=0 on the next cycle, PC=0.
- With CTRL_SINGLE_STEP_EN: no `MemRead` for 10 cycles without `step`. One `step` pulse → exactly one instruction completes, then STEPWAIT.

Source files
------------

// File: rtl/control_fsm.sv
// Multicycle control unit: fetch/decode/execute sequencer for the 8-bit DE10-Lite datapath.
// Optional single-step mode is enabled by defining CTRL_SINGLE_STEP_EN.
module control_fsm #(
    parameter logic [7:0] PC_RESET = 8'h00
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       step,
    input  logic [7:0] Data_out,
    input  logic [7:0] dataA,
    input  logic [7:0] dataB,
    input  logic       N,
    input  logic       Z,
    output logic       MemRead,
    output logic       MemWrite,
    output logic [7:0] ADDR,
    output logic [7:0] Data_in,
    output logic [2:0] ALUop,
    output logic       RFWrite,
    output logic [1:0] regA,
    output logic [1:0] regB,
    output logic [1:0] regW,
    output logic       WBsel,
    output logic [7:0] PC,
    output logic [7:0] IR,
    output logic       halted
);

    typedef enum logic [3:0] {
        S_RST,
        S_FETCH,
        S_FWAIT,
        S_DECODE,
        S_LDRD,
        S_LDWB,
        S_ST,
        S_ALUWB,
        S_BR,
        S_HALT,
        S_STEPWAIT
    } state_t;

    // Every "return to fetch" goes through this, so single-step only touches one place.
`ifdef CTRL_SINGLE_STEP_EN
    localparam state_t S_RESUME = S_STEPWAIT;
`else
    localparam state_t S_RESUME = S_FETCH;
`endif

    state_t     state;
    logic       nf;
    logic       zf;
    logic [3:0] opcode;
    logic [3:0] imm4;
    logic [2:0] alu_sel;
    logic       br_taken;

    assign opcode  = IR[3:0];
    assign imm4    = IR[7:4];
    assign regA    = IR[7:6];
    assign regB    = IR[5:4];
    assign regW    = IR[7:6];
    assign Data_in = dataA;
    assign halted  = (state == S_HALT);

    always_comb begin
        alu_sel = 3'b000;
        case (opcode)
            4'h3:    alu_sel = 3'b001;
            4'h4:    alu_sel = 3'b010;
            default: alu_sel = 3'b000;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (opcode)
            4'h5:    br_taken = zf;
            4'h6:    br_taken = ~zf;
            4'h7:    br_taken = ~nf;
            default: br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= S_RST;
            PC    <= PC_RESET;
            IR    <= '0;
            nf    <= 1'b0;
            zf    <= 1'b0;
        end else begin
            case (state)
                S_RST:   state <= S_RESUME;
                S_FETCH: state <= S_FWAIT;
                S_FWAIT: begin
                    IR    <= Data_out;
                    PC    <= PC + 8'd1;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    case (opcode)
                        4'h0:             state <= S_LDRD;
                        4'h1:             state <= S_ST;
                        4'h2, 4'h3, 4'h4: state <= S_ALUWB;
                        4'h5, 4'h6, 4'h7: state <= S_BR;
                        4'h8:             state <= S_HALT;
                        default:          state <= S_RESUME;
                    endcase
                end
                S_LDRD:  state <= S_LDWB;
                S_LDWB:  state <= S_RESUME;
                S_ST:    state <= S_RESUME;
                S_ALUWB: begin
                    nf    <= N;
                    zf    <= Z;
                    state <= S_RESUME;
                end
                S_BR: begin
                    // Offset applies to the PC already incremented in FWAIT.
                    if (br_taken) begin
                        PC <= PC + {{4{imm4[3]}}, imm4};
                    end
                    state <= S_RESUME;
                end
                S_HALT:  state <= S_HALT;
                S_STEPWAIT: begin
                    if (step) begin
                        state <= S_FETCH;
                    end
                end
                default: state <= S_RST;
            endcase
        end
    end

    always_comb begin
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        ADDR     = '0;
        ALUop    = 3'b000;
        RFWrite  = 1'b0;
        WBsel    = 1'b0;
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                ADDR    = PC;
            end
            S_DECODE: ALUop = alu_sel;
            S_LDRD: begin
                MemRead = 1'b1;
                ADDR    = dataB;
            end
            S_LDWB: begin
                RFWrite = 1'b1;
                WBsel   = 1'b1;
            end
            S_ST: begin
                MemWrite = 1'b1;
                ADDR     = dataB;
            end
            S_ALUWB: begin
                RFWrite = 1'b1;
                ALUop   = alu_sel;
            end
            default: begin
                MemRead = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: surrounds the FSM with a memory, register file and ALU model,
// scoreboards every register/memory write and checks cycle-level strobe timing.
module tb_control_fsm;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       step;
    logic [7:0] Data_out;
    logic [7:0] dataA;
    logic [7:0] dataB;
    logic       N;
    logic       Z;
    logic       MemRead;
    logic       MemWrite;
    logic [7:0] ADDR;
    logic [7:0] Data_in;
    logic [2:0] ALUop;
    logic       RFWrite;
    logic [1:0] regA;
    logic [1:0] regB;
    logic [1:0] regW;
    logic       WBsel;
    logic [7:0] PC;
    logic [7:0] IR;
    logic       halted;

    control_fsm #(.PC_RESET(8'h00)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .step     (step),
        .Data_out (Data_out),
        .dataA    (dataA),
        .dataB    (dataB),
        .N        (N),
        .Z        (Z),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .ADDR     (ADDR),
        .Data_in  (Data_in),
        .ALUop    (ALUop),
        .RFWrite  (RFWrite),
        .regA     (regA),
        .regB     (regB),
        .regW     (regW),
        .WBsel    (WBsel),
        .PC       (PC),
        .IR       (IR),
        .halted   (halted)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Datapath model: memory and register file reload from prog/rinit while reset is held.
    logic [7:0] prog  [256];
    logic [7:0] mem   [256];
    logic [7:0] rinit [4];
    logic [7:0] regs  [4];
    logic [7:0] alu_y;
    logic [7:0] wdata;

    always_comb begin
        alu_y = 8'h00;
        case (ALUop)
            3'b000:  alu_y = dataA + dataB;
            3'b001:  alu_y = dataA - dataB;
            3'b010:  alu_y = ~(dataA & dataB);
            default: alu_y = 8'h00;
        endcase
    end

    assign dataA = regs[regA];
    assign dataB = regs[regB];
    assign N     = alu_y[7];
    assign Z     = (alu_y == 8'h00);
    assign wdata = WBsel ? Data_out : alu_y;

    always @(posedge CLOCK_50) begin
        if (reset) begin
            mem      <= prog;
            regs     <= rinit;
            Data_out <= 8'h00;
        end else begin
            if (MemRead)  Data_out <= mem[ADDR];
            if (MemWrite) mem[ADDR] <= Data_in;
            if (RFWrite)  regs[regW] <= wdata;
        end
    end

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic       is_mem;
        logic [7:0] loc;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;

    always @(negedge CLOCK_50) begin
        if (RFWrite || MemWrite) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(1), 32'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_kind", 32'(MemWrite), 32'(mon_e.is_mem));
                check("wr_loc", 32'(MemWrite ? ADDR : {6'b0, regW}), 32'(mon_e.loc));
                check("wr_data", 32'(MemWrite ? Data_in : wdata), 32'(mon_e.data));
            end
        end
    end

    task automatic tick();
        @(negedge CLOCK_50);
    endtask

    task automatic fill_prog(input logic [7:0] v);
        for (int i = 0; i < 256; i++) prog[i] = v;
    endtask

    task automatic start();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic wait_fetch(input logic [7:0] a, input int unsigned max, output logic ok);
        ok = 1'b0;
        for (int unsigned i = 0; i < max && !ok; i++) begin
            tick();
            if (MemRead && ADDR == a && PC == a) ok = 1'b1;
        end
    endtask

    logic [7:0] br_sub [5] = '{8'h03, 8'h13, 8'h13, 8'h43, 8'h13};
    logic [7:0] br_ins [5] = '{8'hE5, 8'hE5, 8'hE6, 8'hE7, 8'hE7};
    logic [1:0] br_reg [5] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
    logic [7:0] br_val [5] = '{8'h00, 8'h02, 8'h02, 8'hFE, 8'h02};
    logic [7:0] br_pc  [5] = '{8'h04, 8'h06, 8'h04, 8'h06, 8'h04};

    initial begin
        logic ok;
        int unsigned cnt;
        reset = 1'b1;
        step  = 1'b0;
        fill_prog(8'h08);
        rinit = '{8'h00, 8'h00, 8'h00, 8'h00};
        repeat (2) tick();
        check("rst_memread", 32'(MemRead), 32'(0));
        check("rst_memwrite", 32'(MemWrite), 32'(0));
        check("rst_rfwrite", 32'(RFWrite), 32'(0));
        check("rst_addr", 32'(ADDR), 32'(0));
        check("rst_pc", 32'(PC), 32'(0));
        check("rst_ir", 32'(IR), 32'(0));
        check("rst_halted", 32'(halted), 32'(0));

`ifdef CTRL_SINGLE_STEP_EN
        fill_prog(8'h08);
        prog[0] = 8'h12;
        rinit = '{8'h03, 8'h04, 8'h00, 8'h00};
        exp_q.push_back('{1'b0, 8'd0, 8'h07});
        start();
        cnt = 0;
        repeat (10) begin tick(); if (MemRead) cnt++; end
        check("ss_idle_noread", cnt, 0);
        step = 1'b1;
        tick();
        step = 1'b0;
        check("ss_fetch_rd", 32'(MemRead), 32'(1));
        check("ss_fetch_addr", 32'(ADDR), 32'(0));
        repeat (3) tick();
        check("ss_rfwrite", 32'(RFWrite), 32'(1));
        tick();
        check("ss_wait_rd", 32'(MemRead), 32'(0));
        check("ss_wait_pc", 32'(PC), 32'(1));
        cnt = 0;
        repeat (10) begin tick(); if (MemRead) cnt++; end
        check("ss_after_noread", cnt, 0);
`else
        // ADD r0,r1 then STOP
        fill_prog(8'h08);
        prog[0] = 8'h12;
        rinit = '{8'h03, 8'h04, 8'h00, 8'h00};
        exp_q.push_back('{1'b0, 8'd0, 8'h07});
        start();
        tick();
        check("add_fetch_rd", 32'(MemRead), 32'(1));
        check("add_fetch_addr", 32'(ADDR), 32'(0));
        repeat (3) tick();
        check("add_rfwrite", 32'(RFWrite), 32'(1));
        check("add_regw", 32'(regW), 32'(0));
        check("add_aluop", 32'(ALUop), 32'(0));
        check("add_wbsel", 32'(WBsel), 32'(0));
        check("add_pc", 32'(PC), 32'(1));
        tick();
        check("add_next_rd", 32'(MemRead), 32'(1));
        check("add_next_addr", 32'(ADDR), 32'(1));
        repeat (3) tick();
        check("stop_halted", 32'(halted), 32'(1));
        cnt = 0;
        step = 1'b1;
        repeat (20) begin tick(); if (MemRead) cnt++; end
        step = 1'b0;
        check("stop_noread", cnt, 0);
        check("stop_still_halted", 32'(halted), 32'(1));
        check("stop_pc", 32'(PC), 32'(2));

        // LOAD r2 <- M[r3]
        fill_prog(8'h08);
        prog[0]     = 8'hB0;
        prog[8'h40] = 8'h5A;
        rinit = '{8'h00, 8'h00, 8'h00, 8'h40};
        exp_q.push_back('{1'b0, 8'd2, 8'h5A});
        start();
        repeat (4) tick();
        check("ld_rd", 32'(MemRead), 32'(1));
        check("ld_addr", 32'(ADDR), 32'(8'h40));
        check("ld_rd_norfw", 32'(RFWrite), 32'(0));
        tick();
        check("ld_rfwrite", 32'(RFWrite), 32'(1));
        check("ld_wbsel", 32'(WBsel), 32'(1));
        check("ld_regw", 32'(regW), 32'(2));
        tick();
        check("ld_next_rd", 32'(MemRead), 32'(1));
        check("ld_next_addr", 32'(ADDR), 32'(1));
        repeat (3) tick();

        // STORE M[r0] <- r1
        fill_prog(8'h08);
        prog[0] = 8'h41;
        rinit = '{8'h20, 8'h0A, 8'h00, 8'h00};
        exp_q.push_back('{1'b1, 8'h20, 8'h0A});
        start();
        repeat (4) tick();
        check("st_memwrite", 32'(MemWrite), 32'(1));
        check("st_addr", 32'(ADDR), 32'(8'h20));
        check("st_data", 32'(Data_in), 32'(8'h0A));
        tick();
        check("st_one_cycle", 32'(MemWrite), 32'(0));
        check("st_next_addr", 32'(ADDR), 32'(1));
        repeat (3) tick();
        check("st_mem", 32'(mem[8'h20]), 32'(8'h0A));

        // Reset asserted during ST, then held
        exp_q.push_back('{1'b1, 8'h20, 8'h0A});
        start();
        repeat (4) tick();
        reset = 1'b1;
        tick();
        check("rst_mid_memwrite", 32'(MemWrite), 32'(0));
        check("rst_mid_pc", 32'(PC), 32'(0));
        check("rst_mid_addr", 32'(ADDR), 32'(0));
        tick();
        check("rst_held_rd", 32'(MemRead), 32'(0));

        // Branches: SUB at 4 sets flags, branch at 5
        for (int i = 0; i < 5; i++) begin
            fill_prog(8'h08);
            for (int j = 0; j < 4; j++) prog[j] = 8'h09;
            prog[4] = br_sub[i];
            prog[5] = br_ins[i];
            rinit = '{8'h05, 8'h03, 8'h00, 8'h00};
            exp_q.push_back('{1'b0, {6'b0, br_reg[i]}, br_val[i]});
            start();
            wait_fetch(8'h05, 60, ok);
            check("br_reach", 32'(ok), 32'(1));
            repeat (3) tick();
            check("br_pc_inc", 32'(PC), 32'(6));
            tick();
            check("br_pc", 32'(PC), 32'(br_pc[i]));
            check("br_fetch_addr", 32'(ADDR), 32'(br_pc[i]));
            reset = 1'b1;
        end

        // Branch at 0xFF: increment wraps, then offset -2
        fill_prog(8'h09);
        prog[0]     = 8'h03;
        prog[8'hFF] = 8'hE5;
        rinit = '{8'h05, 8'h00, 8'h00, 8'h00};
        exp_q.push_back('{1'b0, 8'd0, 8'h00});
        start();
        wait_fetch(8'hFF, 1200, ok);
        check("wrap_reach", 32'(ok), 32'(1));
        repeat (4) tick();
        check("wrap_pc", 32'(PC), 32'(8'hFE));
        check("wrap_addr", 32'(ADDR), 32'(8'hFE));
        reset = 1'b1;
        tick();
`endif
        check("sb_empty", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
